// File: rtl/acc_pkg.sv
// Shared constants, UART state encoding and ASCII helpers for the accumulator datapath.
package acc_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_L  = 8'h4C;

  // Index of the last byte of a report line (4 chars + CR + LF).
  localparam logic [2:0] LAST_BYTE_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START_BIT = 2'd1,
    ST_DATA_BITS = 2'd2,
    ST_STOP_BIT  = 2'd3
  } uart_state_t;

  // Uppercase hex digit for a nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/acc_uart_tx_if.sv
// Request/status bundle between the line sender and whoever asks for a report.
interface acc_uart_tx_if;
  logic        start;
  logic [15:0] value;
  logic        overflow;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, value, overflow, input tx, busy, done);
  modport slave  (input start, value, overflow, output tx, busy, done);
endinterface

// File: rtl/acc_uart_tx_byte.sv
// Single-byte 8N1 serializer. Ready is also raised in the last cycle of the
// stop bit so the next byte can follow with no idle gap.
//
// state        | meaning
// ST_IDLE      | line high, waiting for i_valid
// ST_START_BIT | driving the low start bit
// ST_DATA_BITS | shifting out 8 data bits, LSB first
// ST_STOP_BIT  | driving the high stop bit
module uart_tx_byte
  import acc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == '0);
  assign o_ready   = (r_state == ST_IDLE) || ((r_state == ST_STOP_BIT) && w_bit_end);
  assign o_tx      = r_tx;

  // Bit sequencer: down-counter per bit, terminal count advances the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_state <= ST_START_BIT;
            r_cnt   <= CNT_LOAD;
            r_shift <= i_data;
            r_tx    <= 1'b0;
          end
        end
        ST_START_BIT: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA_BITS;
            r_cnt     <= CNT_LOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DATA_BITS: begin
          if (w_bit_end) begin
            r_cnt <= CNT_LOAD;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP_BIT;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_STOP_BIT: begin
          if (w_bit_end) begin
            if (i_valid) begin
              r_state <= ST_START_BIT;
              r_cnt   <= CNT_LOAD;
              r_shift <= i_data;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/acc_uart_tx.sv
// Reports the accumulator as one ASCII line ("HHHH\r\n" or "OFLO\r\n") over UART.
// Owns request acceptance, data latching and byte sequencing; the serializer
// does the bit framing.
module acc_uart_tx
  import acc_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst,
  acc_uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_byte_idx;
  logic [15:0] r_value;
  logic        r_ovf;

  logic        w_accept;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic [2:0]  w_next_idx;
  logic [7:0]  w_data;
  logic        w_tx;

  function automatic logic [7:0] line_byte(input logic [2:0] idx, input logic [15:0] v,
                                           input logic ovf);
    case (idx)
      3'd0:    return ovf ? ASCII_O : nibble_to_ascii(v[15:12]);
      3'd1:    return ovf ? ASCII_F : nibble_to_ascii(v[11:8]);
      3'd2:    return ovf ? ASCII_L : nibble_to_ascii(v[7:4]);
      3'd3:    return ovf ? ASCII_O : nibble_to_ascii(v[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  // The first byte is handed over in the accept cycle straight from the inputs,
  // so the start bit appears on the very next cycle.
  assign w_accept   = !r_busy && bus.start;
  assign w_next_idx = r_byte_idx + 3'd1;
  assign w_valid    = w_accept || (r_busy && (r_byte_idx != LAST_BYTE_IDX));
  assign w_data     = r_busy ? line_byte(w_next_idx, r_value, r_ovf)
                             : line_byte(3'd0, bus.value, bus.overflow);
  assign w_last     = r_busy && (r_byte_idx == LAST_BYTE_IDX) && w_ready;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid),
    .i_data  (w_data),
    .o_ready (w_ready),
    .o_tx    (w_tx)
  );

  // Line sequencer: latch on accept, advance per byte handoff, pulse done at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= 3'd0;
      r_value    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= 3'd0;
        r_value    <= bus.value;
        r_ovf      <= bus.overflow;
      end else if (w_last) begin
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_byte_idx <= 3'd0;
      end else if (r_busy && w_valid && w_ready) begin
        r_byte_idx <= w_next_idx;
      end
    end
  end

  assign bus.tx   = w_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: doc/acc_uart_tx.md
Name: acc_uart_tx

Overview:
Reader/transmitter end of the accumulator datapath. Captures the 16-bit accumulated value and overflow flag on a start pulse. Streams them to a host as one ASCII line over 8N1 UART: four uppercase hex digits, then CR LF, or "OFLO" CR LF when overflow is set. Sits beside the accumulator and 7-seg driver in top; tx goes to the board USB-UART pin.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 868 at defaults), clock cycles per UART bit; must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to send current value
value  input  16  accumulated value to report
overflow  input  1  accumulator overflow flag
tx  output  1  UART serial line, idle high
busy  output  1  high while a line is in flight
done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset: clk, rst synchronous active-high. tx=1, busy=0, done=0, all counters 0, state IDLE.
- Accept: start is sampled only in IDLE. On acceptance, latch value and overflow. busy=1 from the next cycle. start is ignored while busy=1.
- Line content, 6 bytes, fixed:
  - overflow=0: hex(value[15:12]), hex([11:8]), hex([7:4]), hex([3:0]), 0x0D, 0x0A.
  - overflow=1: 0x4F 'O', 0x46 'F', 0x4C 'L', 0x4F 'O', 0x0D, 0x0A.
- Hex mapping: nibble 0-9 -> 0x30+n; nibble A-F -> 0x37+n (uppercase).
- Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds exactly CLKS_PER_BIT cycles.
- Timing:
  - First start bit drives tx on the cycle after start is accepted.
  - Bytes are back-to-back with no idle gap between stop bit and next start bit.
  - Total line = 60*CLKS_PER_BIT cycles.
- State machine: IDLE -> START_BIT -> DATA_BITS (bit index 0..7) -> STOP_BIT.
  - STOP_BIT -> START_BIT if byte index < 5, else -> IDLE.
  - Byte index counts 0..5 and clears in IDLE.
- Completion: on the first IDLE cycle after the final stop bit, done=1 for one cycle and busy=0. A start in that same cycle is accepted; the next line begins the following cycle.
- Latched data: value and overflow changing mid-line have no effect on the line in flight.
- Reset mid-line: the line is abandoned. tx=1 and busy=0 on the cycle after rst is sampled. No done pulse is issued.
- Simultaneous rst and start: reset wins; start is dropped.

Decomposition:
- Shared package acc_pkg:
  - ASCII constants CR=8'h0D, LF=8'h0A.
  - Overflow message bytes O, F, L.
  - UART state encoding (IDLE, START_BIT, DATA_BITS, STOP_BIT).
  - Helper function nibble_to_ascii.
- Sub-module uart_tx_byte:
  - Single-byte 8N1 serializer with a data_valid/ready handshake and the CLKS_PER_BIT parameter.
  - Instantiated once by acc_uart_tx, which owns line sequencing and data latching.

Test Plan:
- Sim params CLK_FREQ=16, BAUD=1 (16 cycles/bit). value=16'h1A2F, overflow=0, start pulse -> decoded bytes 0x31,0x41,0x32,0x46,0x0D,0x0A; done pulses exactly 960 cycles after the first start-bit edge; busy high throughout.
- overflow=1, value=16'h1234, start -> bytes 0x4F,0x46,0x4C,0x4F,0x0D,0x0A; value ignored.
- value=16'h0000 then 16'hFFFF in two lines -> "0000\r\n" (0x30 x4) then "FFFF\r\n" (0x46 x4). Boundary nibbles 0 and F verified.
- start re-pulsed while busy, and value changed to 16'hBEEF mid-line -> original line unchanged, no second line queued. A start on the done cycle -> new line starts next cycle with no gap.
- rst asserted during byte 2 data bits -> tx=1 and busy=0 one cycle later, no done. A following start with value=16'h00A5 -> clean "00A5\r\n".
- Bit-timing check: measure every tx transition across one line -> all intervals are multiples of 16 cycles; stop bits high, start bits low.
